midway8080_vram_arbiter: RTL

//  Shares the single-port 7 KB Midway 8080 video RAM between two requesters:
//  the 8080 CPU bus (0x2400-0x3FFF) and the video fetch path. The fetch path

---
 rtl/midway8080_vram_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/midway8080_vram_arbiter.sv
// ---------------------------------------------------------------------------
// midway8080_vram_arbiter
//
// Shares the single-port 7 KB Midway 8080 video RAM between the 8080 CPU bus
// and the video fetch path.
//   - During active scan, video wins contention. The CPU wins once it has
//     waited CPU_MAX_WAIT cycles, which bounds CPU starvation.
//   - During blanking, the CPU always wins contention.
//   - Read data comes back one cycle after the grant, on the port of the
//     requester that owned that RAM cycle.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   vid_active              1 = active scan, 0 = blanking
//   vid_req/vid_addr        video read request, {column[7:0], byte[4:0]}
//   vid_gnt                 video request accepted this cycle
//   vid_rdata_valid/_rdata  video read return (cycle after vid_gnt)
//   cpu_req/_we/_addr/_wdata  CPU request, 16-bit 8080 byte address
//   cpu_gnt                 CPU request accepted this cycle
//   cpu_rdata_valid/_rdata  CPU read return (cycle after a read grant)
//   ram_addr/_we/_wdata     shared RAM controls, sampled at the end of the cycle
//   ram_rdata               shared RAM read data, one-cycle synchronous latency
// ---------------------------------------------------------------------------
module midway8080_vram_arbiter #(
    parameter logic [15:0] VRAM_BASE    = 16'h2400,
    parameter int          VRAM_BYTES   = 7168,
    parameter int          CPU_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_active,
    // video fetch port
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_gnt,
    output logic        vid_rdata_valid,
    output logic [7:0]  vid_rdata,
    // CPU port
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rdata_valid,
    output logic [7:0]  cpu_rdata,
    // shared RAM
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    // CPU window bounds are compared in 17 bits so that the end address of a
    // window reaching the top of the 64 KB space cannot wrap.
    localparam logic [16:0] WIN_LO    = 17'(VRAM_BASE);
    localparam logic [16:0] WIN_HI    = 17'(VRAM_BASE) + 17'(VRAM_BYTES);
    localparam logic [13:0] VID_LIMIT = 14'(VRAM_BYTES);
    localparam logic [3:0]  MAX_WAIT  = 4'(CPU_MAX_WAIT);
    localparam logic [3:0]  WAIT_SAT  = 4'hF;

    // Owner of the RAM cycle granted last cycle. This selects which return
    // port pulses valid and whether it carries RAM data or a forced zero.
    typedef enum logic [2:0] {
        RET_NONE,
        RET_VID,
        RET_CPU,
        RET_ZERO_VID,
        RET_ZERO_CPU
    } ret_state_e;

    typedef struct packed {
        logic vid;
        logic cpu;
    } gnt_t;

    typedef struct packed {
        logic [12:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } ram_ctl_t;

    ret_state_e  ret_state_q, ret_state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [12:0] ram_addr_q, ram_addr_d;

    gnt_t        gnt;
    ram_ctl_t    ram_ctl;
    logic        cpu_wins;
    logic        cpu_in_win;
    logic [12:0] cpu_off;
    logic        vid_in_range;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    always_comb begin
        cpu_in_win   = ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
        // Only the low 13 bits of the offset reach the RAM. Subtracting in
        // 13 bits gives the same result as taking off[12:0] of a full
        // 16-bit subtraction.
        cpu_off      = cpu_addr[12:0] - VRAM_BASE[12:0];
        // Columns 224..255 lie beyond the RAM. They are granted but not fetched.
        vid_in_range = ({1'b0, vid_addr} < VID_LIMIT);
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        // During active scan the CPU wins only after its starvation bound.
        // During blanking the CPU always wins.
        cpu_wins = cpu_req &&
                   (!vid_req || !vid_active || (wait_cnt_q >= MAX_WAIT));
        gnt.cpu  = !reset && cpu_wins;
        gnt.vid  = !reset && vid_req && !cpu_wins;
    end

    // The wait counter measures consecutive cycles in which a pending CPU
    // request lost arbitration. It saturates rather than wrapping.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!cpu_req || gnt.cpu) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != WAIT_SAT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // RAM controls and return bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        // Idle cycles and grants without a RAM access keep the previous
        // address on the RAM bus.
        ram_addr_d    = ram_addr_q;
        ram_ctl.we    = 1'b0;
        ram_ctl.wdata = 8'h00;
        ret_state_d   = RET_NONE;

        if (gnt.cpu) begin
            if (cpu_in_win) begin
                ram_addr_d = cpu_off;
                if (cpu_we) begin
                    ram_ctl.we    = 1'b1;
                    ram_ctl.wdata = cpu_wdata;
                end else begin
                    ret_state_d = RET_CPU;
                end
            end else if (!cpu_we) begin
                // A read outside the window still completes and returns zero.
                // A write outside the window is accepted and dropped.
                ret_state_d = RET_ZERO_CPU;
            end
        end else if (gnt.vid) begin
            if (vid_in_range) begin
                ram_addr_d  = vid_addr;
                ret_state_d = RET_VID;
            end else begin
                ret_state_d = RET_ZERO_VID;
            end
        end

        ram_ctl.addr = reset ? 13'd0 : ram_addr_d;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_state_q <= RET_NONE;
            wait_cnt_q  <= 4'd0;
            ram_addr_q  <= 13'd0;
        end else begin
            ret_state_q <= ret_state_d;
            wait_cnt_q  <= wait_cnt_d;
            ram_addr_q  <= ram_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vid_gnt   = gnt.vid;
    assign cpu_gnt   = gnt.cpu;
    assign ram_addr  = ram_ctl.addr;
    assign ram_we    = ram_ctl.we;
    assign ram_wdata = ram_ctl.wdata;

    // Returns are decoded from last cycle's owner. They are also gated by
    // reset, so a read that was in flight when reset arrived produces no
    // pulse.
    always_comb begin
        vid_rdata_valid = 1'b0;
        vid_rdata       = 8'h00;
        cpu_rdata_valid = 1'b0;
        cpu_rdata       = 8'h00;
        if (!reset) begin
            case (ret_state_q)
                RET_VID: begin
                    vid_rdata_valid = 1'b1;
                    vid_rdata       = ram_rdata;
                end
                RET_ZERO_VID: vid_rdata_valid = 1'b1;
                RET_CPU: begin
                    cpu_rdata_valid = 1'b1;
                    cpu_rdata       = ram_rdata;
                end
                RET_ZERO_CPU: cpu_rdata_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
